// File: rtl/iq_buffer.sv
// Circular instruction queue: up to two decoded instructions in per cycle, one out at the head.
// Raises stall_from_decode when a two-wide push cannot be guaranteed room.
module iq_buffer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [1:0]                 push_num,
  input  logic [WIDTH-1:0]           push_data0,
  input  logic [WIDTH-1:0]           push_data1,
  input  logic                       stall_to_id_is,
  input  logic                       stall_to_is,
  input  logic                       flash_to_iq,
  input  logic                       pop_ready,
  output logic                       head_valid,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       stall_from_decode,
  output logic                       overflow_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  logic [1:0]       eff_push;
  logic [1:0]       acc_push;
  logic [CNT_W-1:0] room;
  logic             do_pop;

  // Push truncation against free space seen at the start of the cycle; a same-cycle pop frees nothing.
  always_comb begin
    eff_push = 2'd0;
    if (!stall_to_id_is) begin
      eff_push = push_num[1] ? 2'd2 : push_num;
    end
    room     = CNT_W'(DEPTH) - count_q;
    acc_push = eff_push;
    if (CNT_W'(eff_push) > room) begin
      acc_push = room[1:0];
    end
    do_pop = (count_q != '0) && pop_ready && !stall_to_is;
  end

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (flash_to_iq) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (acc_push != 2'd0) begin
        mem_d[wr_ptr_q] = push_data0;
      end
      if (acc_push == 2'd2) begin
        mem_d[wr_ptr_q + PTR_W'(1)] = push_data1;
      end
      wr_ptr_d   = wr_ptr_q + PTR_W'(acc_push);
      rd_ptr_d   = rd_ptr_q + PTR_W'(do_pop);
      count_d    = count_q + CNT_W'(acc_push) - CNT_W'(do_pop);
      overflow_d = overflow_q | (acc_push != eff_push);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry storage needs no reset: contents are masked by head_valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_valid        = (count_q != '0);
  assign head_data         = head_valid ? mem_q[rd_ptr_q] : '0;
  assign count             = count_q;
  assign stall_from_decode = (count_q >= CNT_W'(DEPTH - 1));
  assign overflow_err      = overflow_q;

endmodule
